// File: rtl/sync_scenario_ctrl.sv
// Scenario sequencer: synchronises external trigger/sense inputs and steps a timed
// detonate/acquire sequence, counting completed scenarios.
module sync_scenario_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_signal,
  input  logic             start_signal,
  input  logic             fg_signal,
  input  logic             phase_signal,
  input  logic             wire_signal,
  input  logic             detector_ready,
  input  logic [CNT_W-1:0] fg_open_delay,
  input  logic [CNT_W-1:0] detectr_ready_timeout,
  input  logic [CNT_W-1:0] phase_shift,
  input  logic [CNT_W-1:0] detonate_len,
  input  logic [CNT_W-1:0] trigger_len,
  output logic             detonation_signal,
  output logic             output_trigger,
  output logic [7:0]       scenario_state,
  output logic [CNT_W-1:0] counter_out
);

  typedef enum logic [7:0] {
    StIdle       = 8'h00,
    StWaitFg     = 8'h01,
    StFgDelay    = 8'h02,
    StWaitReady  = 8'h03,
    StWaitPhase  = 8'h04,
    StPhaseDelay = 8'h05,
    StDetonate   = 8'h06,
    StWaitWire   = 8'h07,
    StTrigger    = 8'h08,
    StDone       = 8'h09,
    StTimeout    = 8'hE0
  } state_e;

  localparam int unsigned NIn = 5;

  logic [NIn-1:0]       async_in;
  logic [NIn-1:0]       sync_q [SYNC_STAGES];
  logic [NIn-1:0]       sync_lvl;
  logic [3:0]           sync_dly_q;
  logic [SYNC_STAGES:0] armed_q;
  logic [3:0]           rise;
  logic                 start_rise, fg_rise, phase_rise, wire_rise, ready_lvl;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_last;

  assign async_in = {detector_ready, wire_signal, phase_signal, fg_signal, start_signal};

  always_ff @(posedge clk or posedge reset_signal) begin
    if (reset_signal) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_dly_q <= '0;
      armed_q    <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_dly_q <= sync_lvl[3:0];
      armed_q    <= {armed_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are masked until the synchronisers have refilled after reset, so a level
  // already high at reset release is not mistaken for a rising edge.
  assign sync_lvl   = sync_q[SYNC_STAGES-1];
  assign rise       = sync_lvl[3:0] & ~sync_dly_q & {4{armed_q[SYNC_STAGES]}};
  assign start_rise = rise[0];
  assign fg_rise    = rise[1];
  assign phase_rise = rise[2];
  assign wire_rise  = rise[3];
  assign ready_lvl  = sync_lvl[4];

  // A loaded value of 0 or 1 both mean a single cycle in the timed state.
  assign cnt_last = (cnt_q <= CNT_W'(1));

  always_ff @(posedge clk or posedge reset_signal) begin
    if (reset_signal) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: if (start_rise) state_d = StWaitFg;
      StWaitFg: begin
        if (fg_rise) begin
          state_d = StFgDelay;
          cnt_d   = fg_open_delay;
        end
      end
      StFgDelay: begin
        if (cnt_last) begin
          state_d = StWaitReady;
          cnt_d   = detectr_ready_timeout;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // In the wait states a counter value of 0 means the timeout is disabled.
      StWaitReady: begin
        if (ready_lvl) begin
          state_d = StWaitPhase;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = StTimeout;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StWaitPhase: begin
        if (phase_rise) begin
          state_d = StPhaseDelay;
          cnt_d   = phase_shift;
        end
      end
      StPhaseDelay: begin
        if (cnt_last) begin
          state_d = StDetonate;
          cnt_d   = detonate_len;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDetonate: begin
        if (cnt_last) begin
          state_d = StWaitWire;
          cnt_d   = detectr_ready_timeout;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StWaitWire: begin
        if (wire_rise) begin
          state_d = StTrigger;
          cnt_d   = trigger_len;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = StTimeout;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StTrigger: begin
        if (cnt_last) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDone:    state_d = StIdle;
      StTimeout: if (start_rise) state_d = StWaitFg;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are registered copies of the state, so pulses line up with scenario_state.
  always_ff @(posedge clk or posedge reset_signal) begin
    if (reset_signal) begin
      scenario_state    <= 8'h00;
      detonation_signal <= 1'b0;
      output_trigger    <= 1'b0;
      counter_out       <= '0;
    end else begin
      scenario_state    <= state_q;
      detonation_signal <= (state_q == StDetonate);
      output_trigger    <= (state_q == StTrigger);
      if (state_q == StDone) counter_out <= counter_out + CNT_W'(1);
    end
  end

endmodule
